uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter.
//
// Words written through wr/w_data are queued in a 2^FIFO_W-deep FIFO.
// Each word is sent as one frame: a start bit, DBIT data bits (LSB first),
// an optional parity bit and a stop period. Every start, data and parity bit
// lasts OS_TICK s_tick pulses. The stop period lasts SB_TICK pulses.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   s_tick       oversampling enable, one-clk pulse
//   wr           write request; ignored while full
//   w_data       word to transmit (DBIT bits)
//   full         FIFO holds 2^FIFO_W words
//   tx_busy      transmitter is not idle
//   tx_done_tick one-clk pulse when a frame's stop period ends
//   tx           registered serial line, idle high
module uart_tx_param #(
  parameter int DBIT    = 8,
  parameter int OS_TICK = 16,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0,
  parameter int FIFO_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  output logic            full,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int DEPTH = 1 << FIFO_W;
  localparam int TMAX  = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW    = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0]   OS_LAST  = TW'(OS_TICK - 1);
  localparam logic [TW-1:0]   SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(DBIT - 1);
  localparam logic [FIFO_W:0] CNT_FULL = (FIFO_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DBIT-1:0]   shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic [FIFO_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_W:0]   count_q, count_d;

  logic [DBIT-1:0]   mem [DEPTH];
  logic [DBIT-1:0]   head_word;
  logic              empty;
  logic              push;
  logic              pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign head_word = mem[rd_ptr_q];
  assign push      = wr && !full;
  // The FSM takes the head word on the same edge it leaves IDLE.
  assign pop       = (state_q == ST_IDLE) && !empty;

  // Storage array has no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= w_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    done_d   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          shift_d = head_word;
          // Parity is taken from the whole word now, before shifting.
          par_d   = (^head_word) ^ 1'(PARITY == 2);
          tick_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == BIT_LAST) begin
              state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (tick_q == SB_LAST) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line level follows the current state, so tx lags the state by one clk.
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign tx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param. Four configurations share one stimulus stream:
//   0: defaults (DBIT 8, no parity, 1 stop bit, depth 4)
//   1: even parity
//   2: odd parity, SB_TICK=32
//   3: DBIT 5, OS_TICK 8, SB_TICK 1, even parity, depth 2
// The reference model describes each frame as a list of line levels.
// Each start, data and parity level lasts OS_TICK s_ticks, and the stop level
// lasts SB_TICK s_ticks. The model queues words in a bounded FIFO and
// counts consumed s_ticks.
module tb_uart_tx_param;
  localparam int NI = 4;

  logic       clk;
  logic       rst;
  logic       s_tick;
  logic       wr;
  logic [7:0] w_data;
  logic       tx_o   [NI];
  logic       full_o [NI];
  logic       busy_o [NI];
  logic       done_o [NI];

  int checks    = 0;
  int failures  = 0;
  int done_cnt0 = 0;

  // reference model state
  logic [7:0] mq     [NI][64];
  int         head_m [NI];
  int         cnt_m  [NI];
  bit         act_m  [NI];
  int         n_m    [NI];
  logic [7:0] cur_m  [NI];
  logic       etx    [NI];
  logic       efull  [NI];
  logic       ebusy  [NI];
  logic       edone  [NI];

  uart_tx_param u0 (
    .clk(clk), .reset(rst), .s_tick(s_tick), .wr(wr), .w_data(w_data),
    .full(full_o[0]), .tx_busy(busy_o[0]), .tx_done_tick(done_o[0]), .tx(tx_o[0]));
  uart_tx_param #(.PARITY(1)) u1 (
    .clk(clk), .reset(rst), .s_tick(s_tick), .wr(wr), .w_data(w_data),
    .full(full_o[1]), .tx_busy(busy_o[1]), .tx_done_tick(done_o[1]), .tx(tx_o[1]));
  uart_tx_param #(.PARITY(2), .SB_TICK(32)) u2 (
    .clk(clk), .reset(rst), .s_tick(s_tick), .wr(wr), .w_data(w_data),
    .full(full_o[2]), .tx_busy(busy_o[2]), .tx_done_tick(done_o[2]), .tx(tx_o[2]));
  uart_tx_param #(.DBIT(5), .OS_TICK(8), .SB_TICK(1), .PARITY(1), .FIFO_W(1)) u3 (
    .clk(clk), .reset(rst), .s_tick(s_tick), .wr(wr), .w_data(w_data[4:0]),
    .full(full_o[3]), .tx_busy(busy_o[3]), .tx_done_tick(done_o[3]), .tx(tx_o[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int p_dbit(input int i);
    return (i == 3) ? 5 : 8;
  endfunction
  function automatic int p_os(input int i);
    return (i == 3) ? 8 : 16;
  endfunction
  function automatic int p_sb(input int i);
    return (i == 2) ? 32 : ((i == 3) ? 1 : 16);
  endfunction
  function automatic int p_par(input int i);
    return (i == 1 || i == 3) ? 1 : ((i == 2) ? 2 : 0);
  endfunction
  function automatic int p_depth(input int i);
    return (i == 3) ? 2 : 4;
  endfunction
  function automatic int total(input int i);
    return p_os(i) * (1 + p_dbit(i) + ((p_par(i) != 0) ? 1 : 0)) + p_sb(i);
  endfunction

  // Line level after n s_ticks have elapsed in the current frame.
  function automatic logic lvl(input int i, input logic [7:0] w, input int n);
    int os;
    int idx;
    os = p_os(i);
    if (n < os) return 1'b0;
    idx = n / os - 1;
    if (idx < p_dbit(i)) return w[idx];
    if (p_par(i) != 0 && idx == p_dbit(i)) return (^w) ^ (p_par(i) == 2);
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      head_m[i] = 0;
      cnt_m[i]  = 0;
      act_m[i]  = 1'b0;
      n_m[i]    = 0;
      cur_m[i]  = '0;
      etx[i]    = 1'b1;
      efull[i]  = 1'b0;
      ebusy[i]  = 1'b0;
      edone[i]  = 1'b0;
    end
  endtask

  // Advance the model by one rising edge, using the inputs held across it.
  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      logic       pop;
      logic       push;
      logic [7:0] mask;
      mask   = 8'((1 << p_dbit(i)) - 1);
      etx[i] = act_m[i] ? lvl(i, cur_m[i], n_m[i]) : 1'b1;
      pop    = !act_m[i] && (cnt_m[i] > 0);
      push   = wr && (cnt_m[i] < p_depth(i));
      edone[i] = 1'b0;
      if (act_m[i] && s_tick) begin
        n_m[i]++;
        if (n_m[i] == total(i)) begin
          act_m[i] = 1'b0;
          edone[i] = 1'b1;
        end
      end
      if (pop) begin
        cur_m[i]  = mq[i][head_m[i]];
        head_m[i] = (head_m[i] + 1) % p_depth(i);
        cnt_m[i]--;
        act_m[i]  = 1'b1;
        n_m[i]    = 0;
      end
      if (push) begin
        mq[i][(head_m[i] + cnt_m[i]) % p_depth(i)] = w_data & mask;
        cnt_m[i]++;
      end
      efull[i] = (cnt_m[i] == p_depth(i));
      ebusy[i] = act_m[i];
    end
  endtask

  task automatic chk(input string tag, input int i, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] got=%b exp=%b at %0t", tag, i, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk("tx", i, tx_o[i], etx[i]);
      chk("full", i, full_o[i], efull[i]);
      chk("tx_busy", i, busy_o[i], ebusy[i]);
      chk("tx_done_tick", i, done_o[i], edone[i]);
    end
  endtask

  // Drive inputs, take one edge, then compare every output 1 time unit later.
  task automatic step(input logic w, input logic [7:0] d, input logic st);
    wr     = w;
    w_data = d;
    s_tick = st;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (done_o[0] === 1'b1) done_cnt0++;
  endtask

  // Assert reset between edges; outputs must clear before any edge occurs.
  task automatic apply_reset();
    rst    = 1'b1;
    wr     = 1'b0;
    s_tick = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b0;
    wr     = 1'b0;
    s_tick = 1'b0;
    w_data = '0;
    #2;
    apply_reset();

    // Single 0xA5 frame with s_tick on every clk, plus a latency check.
    done_cnt0 = 0;
    step(1'b1, 8'hA5, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("latency_e1_tx", 0, tx_o[0], 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("latency_e2_tx", 0, tx_o[0], 1'b0);
    repeat (297) step(1'b0, 8'h00, 1'b1);
    chk_int("frames_a5", done_cnt0, 1);

    // FIFO fill while transmitting: 4 accepted, 5th dropped.
    done_cnt0 = 0;
    step(1'b1, 8'($urandom), 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'($urandom), 1'b1);
      if (k == 3) chk("full_after_4th", 0, full_o[0], 1'b1);
    end
    repeat (1300) step(1'b0, 8'h00, 1'b1);
    chk_int("frames_fifo", done_cnt0, 5);

    // Reset during data bit 3, then transmit a fresh word.
    done_cnt0 = 0;
    step(1'b1, 8'($urandom), 1'b1);
    repeat (75) step(1'b0, 8'h00, 1'b1);
    apply_reset();
    step(1'b1, 8'($urandom), 1'b1);
    repeat (300) step(1'b0, 8'h00, 1'b1);
    chk_int("frames_after_reset", done_cnt0, 1);

    // s_tick every 4th clk, with a 100-clk s_tick gap during data bits.
    step(1'b1, 8'($urandom), 1'b0);
    for (int c = 0; c < 1000; c++) begin
      step(1'b0, 8'h00, (c % 4 == 3) && !(c >= 300 && c < 400));
    end

    // Random traffic with a reset in the middle.
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) apply_reset();
      step($urandom_range(0, 15) == 0, 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
